// File: rtl/tt_um_leg_solver.sv
// Leg solver: b = floor(sqrt(c*c - a*a)) using a serial shift-add squarer followed
// by a restoring square root. Operands and start arrive as strobes on uio_in.
module tt_um_leg_solver #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = $clog2(WIDTH);
    localparam int SW = 2 * WIDTH;
    localparam int RW = SW + 2;

    typedef enum logic [2:0] {IDLE, SQ_C, SQ_A, SUB, ROOT, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       prev_q;
    logic             go_q;
    logic [WIDTH-1:0] c_q, a_q, mplier_q, root_q, uo_q;
    logic [SW-1:0]    acc_q, mcand_q, csq_q, d_q;
    logic [RW-1:0]    rem_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, err_q, exact_q;

    logic [2:0]       rise;
    logic             idle_like, sq_last, root_last, in_sub, ge;
    logic [SW-1:0]    acc_nx, d_src, d_nx;
    logic [RW-1:0]    rem_src, rem_sh, trial, rem_nx;
    logic [WIDTH-1:0] root_src, root_nx;
    logic             unused_pins;

    assign unused_pins = &{1'b0, uio_in[7:3]};

    assign rise      = uio_in[2:0] & ~prev_q;
    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign sq_last   = (cnt_q == CW'(WIDTH - 1));
    assign root_last = (cnt_q == CW'(WIDTH - 2));
    assign in_sub    = (state_q == SUB);

    assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

    // SUB feeds the fresh difference straight into the first root step, so the
    // remaining WIDTH-1 steps run in ROOT.
    assign d_src    = in_sub ? (csq_q - acc_q) : d_q;
    assign rem_src  = in_sub ? '0 : rem_q;
    assign root_src = in_sub ? '0 : root_q;
    assign rem_sh   = {rem_src[SW-1:0], d_src[SW-1:SW-2]};
    assign trial    = {{WIDTH{1'b0}}, root_src, 2'b01};
    assign ge       = (rem_sh >= trial);
    assign rem_nx   = ge ? (rem_sh - trial) : rem_sh;
    assign root_nx  = {root_src[WIDTH-2:0], ge};
    assign d_nx     = {d_src[SW-3:0], 2'b00};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (go_q) state_d = (a_q > c_q) ? DONE : SQ_C;
            SQ_C:       if (sq_last) state_d = SQ_A;
            SQ_A:       if (sq_last) state_d = SUB;
            SUB:        state_d = ROOT;
            ROOT:       if (root_last) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else if (ena) state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;  go_q <= 1'b0;
            c_q <= '0;  a_q <= '0;  mplier_q <= '0;  root_q <= '0;  uo_q <= '0;
            acc_q <= '0;  mcand_q <= '0;  csq_q <= '0;  d_q <= '0;  rem_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;  exact_q <= 1'b0;
        end else if (ena) begin
            prev_q <= uio_in[2:0];
            go_q   <= rise[2] && idle_like;
            if (!busy_q && !go_q) begin
                if (rise[0]) c_q <= ui_in[WIDTH-1:0];
                if (rise[1]) a_q <= ui_in[WIDTH-1:0];
            end
            case (state_q)
                IDLE, DONE: if (go_q) begin
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                    exact_q  <= 1'b0;
                    cnt_q    <= '0;
                    acc_q    <= '0;
                    mcand_q  <= {{WIDTH{1'b0}}, c_q};
                    mplier_q <= c_q;
                    if (a_q > c_q) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        uo_q   <= '0;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                SQ_C, SQ_A: begin
                    acc_q    <= acc_nx;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (sq_last) begin
                        cnt_q <= '0;
                        if (state_q == SQ_C) begin
                            csq_q    <= acc_nx;
                            acc_q    <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, a_q};
                            mplier_q <= a_q;
                        end
                    end
                end
                SUB, ROOT: begin
                    d_q    <= d_nx;
                    rem_q  <= rem_nx;
                    root_q <= root_nx;
                    cnt_q  <= in_sub ? '0 : cnt_q + 1'b1;
                    if (!in_sub && root_last) begin
                        uo_q    <= root_nx;
                        exact_q <= (rem_nx == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = {exact_q, err_q, done_q, busy_q, 4'b0000};
    assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_leg_solver.sv
// Bench for tt_um_leg_solver: vector table through a result scoreboard, plus
// hand-written sequences for back-to-back starts, busy-time abuse, ena stalls and reset.
module tb_tt_um_leg_solver;
    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    tt_um_leg_solver dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] c;
        logic [7:0] a;
        logic [7:0] b;
        bit         ex;
        bit         er;
    } vec_t;

    vec_t tbl[8];
    vec_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int idx, input logic [7:0] v);
        ui_in       = v;
        uio_in[7:3] = 5'($urandom);
        uio_in[idx] = 1'b1;
        tick();
        uio_in[idx] = 1'b0;
        tick();
    endtask

    // Pulse start, optionally stall ena mid-ROOT or abuse the strobes while busy,
    // then wait for done and score the result against the queued expectation.
    task automatic run(input string nm, input vec_t e, input int gap, input bit abuse);
        int  t0, bn;
        bit  got;
        vec_t x;
        sb.push_back(e);
        uio_in[2] = 1'b1;
        tick();
        t0 = cyc;
        uio_in[2] = 1'b0;
        bn = 0;
        got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            if (gap > 0 && cyc - t0 == 20) ena = 1'b0;
            if (gap > 0 && cyc - t0 == 20 + gap) ena = 1'b1;
            if (abuse && cyc - t0 == 9) begin
                ui_in = 8'd99;
                uio_in[2:0] = 3'b101;
            end
            if (abuse && cyc - t0 == 10) uio_in[2:0] = 3'b000;
            tick();
            if (uio_out[4]) bn++;
            if (uio_out[5]) got = 1'b1;
        end
        ena = 1'b1;
        if (!got) begin
            chk({nm, " timeout"}, 0, 1);
        end else begin
            x = sb.pop_front();
            chk({nm, " result"}, int'(uo_out), int'(x.b));
            chk({nm, " exact"}, int'(uio_out[7]), int'(x.ex));
            chk({nm, " error"}, int'(uio_out[6]), int'(x.er));
            chk({nm, " latency"}, cyc - t0, x.er ? 1 : 25 + gap);
            chk({nm, " busy cycles"}, bn, x.er ? 0 : 24 + gap);
        end
    endtask

    initial begin
        int seen;
        tbl[0] = '{c: 8'd5,   a: 8'd3, b: 8'd4,   ex: 1'b1, er: 1'b0};
        tbl[1] = '{c: 8'd13,  a: 8'd5, b: 8'd12,  ex: 1'b1, er: 1'b0};
        tbl[2] = '{c: 8'd17,  a: 8'd8, b: 8'd15,  ex: 1'b1, er: 1'b0};
        tbl[3] = '{c: 8'd10,  a: 8'd3, b: 8'd9,   ex: 1'b0, er: 1'b0};
        tbl[4] = '{c: 8'd3,   a: 8'd4, b: 8'd0,   ex: 1'b0, er: 1'b1};
        tbl[5] = '{c: 8'd255, a: 8'd0, b: 8'd255, ex: 1'b1, er: 1'b0};
        tbl[6] = '{c: 8'd0,   a: 8'd0, b: 8'd0,   ex: 1'b1, er: 1'b0};
        tbl[7] = '{c: 8'd7,   a: 8'd7, b: 8'd0,   ex: 1'b1, er: 1'b0};

        rst_n = 1'b0; ena = 1'b1; ui_in = '0; uio_in = '0;
        repeat (3) tick();
        chk("reset uo_out", int'(uo_out), 0);
        chk("reset uio_out", int'(uio_out), 0);
        chk("uio_oe", int'(uio_oe), 8'hF0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            do_load(0, tbl[i].c);
            do_load(1, tbl[i].a);
            run($sformatf("vec%0d", i), tbl[i], 0, 1'b0);
        end

        // 7,7 left in the registers: restart one cycle after done.
        run("back2back", tbl[7], 0, 1'b0);

        do_load(0, 8'd5);
        do_load(1, 8'd3);
        run("busy abuse", tbl[0], 0, 1'b1);
        run("c kept", tbl[0], 0, 1'b0);
        run("ena stall", tbl[0], 5, 1'b0);

        uio_in[2] = 1'b1;
        tick();
        uio_in[2] = 1'b0;
        repeat (12) tick();
        rst_n = 1'b0;
        #1;
        chk("midrun reset uo_out", int'(uo_out), 0);
        chk("midrun reset uio_out", int'(uio_out), 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            tick();
            if (uio_out[5] || uio_out[4]) seen = 1;
        end
        chk("no done after reset", seen, 0);
        chk("scoreboard empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tt_um_leg_solver.md
Name: tt_um_leg_solver

Overview:
- Inverse companion to the hypotenuse calculator: given hypotenuse c and one leg a, computes the other leg b = floor(sqrt(c² − a²)).
- Operands are loaded serially over ui_in with strobes on uio_in.
- Sequential datapath: shift-add squarer, then restoring digit-by-digit integer square root.
- Tiny Tapeout user-project top; start/busy/done handshake on the uio pins.

Parameters:
- WIDTH, 8, operand/result width. The pin mapping supports only 8; other values are for unit reuse only.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  design enable; 0 = hold all state
- ui_in  input  8  operand data bus
- uio_in  input  8  [0] load_c strobe, [1] load_a strobe, [2] start strobe, [7:3] unused
- uo_out  output  8  result b
- uio_out  output  8  [4] busy, [5] done, [6] error, [7] exact, [3:0] = 0
- uio_oe  output  8  constant 8'hF0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: uo_out=0, busy=0, done=0, error=0, exact=0, c_reg=0, a_reg=0, strobe history=0, FSM=IDLE.
- Reset mid-operation: aborts immediately to the reset values above, with no partial result.
- ena=0: all registers hold, including strobe history. Strobes are ignored.
- Strobe detection: each strobe is registered. A rising edge is prev=0 and current=1 at a clock edge. The edge at which this is detected is the "accepting edge" T.
- Operand load:
  - load_c rising edge: c_reg <= ui_in.
  - load_a rising edge: a_reg <= ui_in.
  - Both in the same cycle: both load the same ui_in value.
  - Loads are ignored while busy=1.
- Start:
  - A start rising edge in IDLE or DONE is accepted. It clears done/error/exact. uo_out holds its old value until completion.
  - Start while busy is ignored. It is not queued.
  - A load and a start on the same edge: the load commits, and the computation uses the new value.
- FSM states: IDLE, SQ_C, SQ_A, SUB, ROOT, DONE.
  - IDLE/DONE --start--> if a_reg > c_reg, go to DONE with error=1, uo_out=0, exact=0, done=1 after edge T+1, busy never asserted.
  - IDLE/DONE --start--> otherwise, go to SQ_C with busy=1 after T.
  - SQ_C: 8 cycles, shift-add computing c² (16-bit, no overflow).
  - SQ_A: 8 cycles computing a².
  - SUB: 1 cycle, D = c² − a². D ≥ 0 is guaranteed by the a ≤ c check. D is 16-bit unsigned.
  - ROOT: 8 iterations of restoring sqrt, one result bit per cycle MSB first, 18-bit remainder.
  - DONE: entered at T+25. At that edge uo_out <= root, exact <= (remainder==0), done=1, busy=0.
- Handshake timing:
  - Normal latency: busy high from T+1 through T+25 (exclusive).
  - done is a level, high from completion until the next accepted start or reset.
  - Result stays stable in DONE.
- Boundaries:
  - a==c gives 0 with exact=1.
  - a=0 gives c with exact=1.
  - Max D = 65025 gives root 255, so the result always fits in 8 bits.
  - uio_in[7:3] are ignored.

Test Plan:
- Reset then load c=5, a=3, pulse start → done at T+25, uo_out=4, exact=1, error=0; busy high exactly 24 cycles.
- c=13, a=5 → 12 exact; then c=17, a=8 → 15 exact. Back-to-back starts, each issued one cycle after done.
- c=10, a=3 (D=91) → uo_out=9, exact=0.
- c=3, a=4 → done at T+1, error=1, uo_out=0, busy never high.
- c=255, a=0 → 255, exact=1; c=0, a=0 → 0, exact=1.
- Protocol abuse, start of c=5, a=3:
  - At T+10, pulse load_c with ui_in=99 and pulse start → result still 4, c_reg still 5.
  - In a separate run, assert rst_n=0 at T+12 → all outputs 0 immediately and no done.
  - ena=0 for 5 cycles mid-ROOT → done delayed exactly 5 cycles with the same result.
